// File: rtl/io_channel_if.sv
// io_channel_if
//   Core-side IO channel bus: one combinational read port and one
//   registered write port, each addressing eight 15-bit channels.
//   Modports:
//     master - the core: drives selects, strobes and write data, receives read data
//     slave  - the responder: receives selects, strobes and write data, drives read data
interface io_channel_if;
  logic [2:0]  IO_read_sel;
  logic        IO_read_en;
  logic [14:0] IO_read_data;
  logic [2:0]  IO_write_sel;
  logic [14:0] IO_write_data;
  logic        IO_write_en;

  modport master (
    output IO_read_sel, IO_read_en, IO_write_sel, IO_write_data, IO_write_en,
    input  IO_read_data
  );

  modport slave (
    input  IO_read_sel, IO_read_en, IO_write_sel, IO_write_data, IO_write_en,
    output IO_read_data
  );
endinterface

// File: rtl/io_channel_responder.sv
// io_channel_responder
//   Target side of the core's IO channel bus. Serves eight 15-bit channels:
//     0 scratch register        1 output latch (out_port)
//     2 synchronised in_port    3 TX FIFO status / push
//     4 RX FIFO head / pop      5 FIFO counts + sticky tx_ovf/rx_udf (W1C)
//     6 timer (IO_TIMER_EN)     7 reserved, reads 0
//   Reads are combinational so the core's decode stage sees data in the same
//   cycle; writes take effect on the next rising clock edge.
//   Optional feature macro: IO_TIMER_EN adds a prescaled 15-bit timer on
//   channel 6 with a sticky wrap flag on timer_irq.
// Ports
//   clock, reset          sole clock; synchronous active-high reset
//   io (slave modport)    IO channel read/write bus
//   out_port  [14:0] out  channel 1 latch
//   in_port   [14:0] in   asynchronous external input, read on channel 2
//   tx_valid/tx_ready/tx_data  downlink stream driven from the TX FIFO head
//   rx_valid/rx_ready/rx_data  uplink stream into the RX FIFO
//   timer_irq        out  sticky timer wrap flag (tied 0 without IO_TIMER_EN)
module io_channel_responder #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMER_DIV  = 16,
  parameter logic [14:0] OUT_RESET  = 15'h0000
) (
  input  logic        clock,
  input  logic        reset,
  io_channel_if.slave io,
  output logic [14:0] out_port,
  input  logic [14:0] in_port,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [14:0] tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [14:0] rx_data,
  output logic        timer_irq
);

  localparam int         PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

  // ---------------- write/read decode ----------------
  logic wr_scratch, wr_out, wr_tx, wr_status;
  logic rx_pop_req;

  assign wr_scratch = io.IO_write_en && (io.IO_write_sel == 3'd0);
  assign wr_out     = io.IO_write_en && (io.IO_write_sel == 3'd1);
  assign wr_tx      = io.IO_write_en && (io.IO_write_sel == 3'd3);
  assign wr_status  = io.IO_write_en && (io.IO_write_sel == 3'd5);
  assign rx_pop_req = io.IO_read_en  && (io.IO_read_sel  == 3'd4);

  // ---------------- simple registers ----------------
  logic [14:0] scratch_reg;
  logic [14:0] out_reg;
  logic [14:0] sync1_reg, sync2_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_reg <= '0;
      out_reg     <= OUT_RESET;
      sync1_reg   <= '0;
      sync2_reg   <= '0;
    end else begin
      if (wr_scratch) scratch_reg <= io.IO_write_data;
      if (wr_out)     out_reg     <= io.IO_write_data;
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
    end
  end

  assign out_port = out_reg;

  // ---------------- TX FIFO (core -> device) ----------------
  logic [14:0]      tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [4:0]       tx_count_reg;
  logic             tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full  = (tx_count_reg == DEPTH_CNT);
  assign tx_empty = (tx_count_reg == 5'd0);
  // Full is judged on the registered count, so a push into a full FIFO is
  // dropped even when the device drains an entry in the same cycle.
  assign tx_push  = wr_tx && !tx_full;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= io.IO_write_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count_reg <= tx_count_reg + 5'd1;
        2'b01:   tx_count_reg <= tx_count_reg - 5'd1;
        default: tx_count_reg <= tx_count_reg;
      endcase
    end
  end

  // ---------------- RX FIFO (device -> core) ----------------
  logic [14:0]      rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [4:0]       rx_count_reg;
  logic             rx_full, rx_empty, rx_push, rx_pop;
  logic [14:0]      rx_head;

  assign rx_full  = (rx_count_reg == DEPTH_CNT);
  assign rx_empty = (rx_count_reg == 5'd0);
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rx_pop_req && !rx_empty;
  // No bypass: a word pushed into an empty FIFO appears on the next cycle.
  assign rx_head  = rx_empty ? 15'h0000 : rx_mem[rx_rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count_reg <= rx_count_reg + 5'd1;
        2'b01:   rx_count_reg <= rx_count_reg - 5'd1;
        default: rx_count_reg <= rx_count_reg;
      endcase
    end
  end

  // ---------------- sticky error flags ----------------
  logic tx_ovf_reg, rx_udf_reg;
  logic tx_ovf_set, rx_udf_set, tx_ovf_clr, rx_udf_clr;

  assign tx_ovf_set = wr_tx && tx_full;
  assign rx_udf_set = rx_pop_req && rx_empty;
  assign tx_ovf_clr = wr_status && io.IO_write_data[14];
  assign rx_udf_clr = wr_status && io.IO_write_data[13];

  // Set has priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_ovf_reg <= 1'b0;
      rx_udf_reg <= 1'b0;
    end else begin
      tx_ovf_reg <= (tx_ovf_reg && !tx_ovf_clr) || tx_ovf_set;
      rx_udf_reg <= (rx_udf_reg && !rx_udf_clr) || rx_udf_set;
    end
  end

  // ---------------- optional timer ----------------
  logic [14:0] timer_rd;

`ifdef IO_TIMER_EN
  localparam int PRE_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TIMER_DIV - 1);

  logic [PRE_W-1:0] prescale_reg;
  logic [14:0]      timer_reg;
  logic             irq_reg;
  logic             wr_timer, tick;

  assign wr_timer = io.IO_write_en && (io.IO_write_sel == 3'd6);
  assign tick     = (prescale_reg == PRE_LAST);

  // A core write fully overrides any tick or wrap landing on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescale_reg <= '0;
      timer_reg    <= '0;
      irq_reg      <= 1'b0;
    end else if (wr_timer) begin
      prescale_reg <= '0;
      timer_reg    <= io.IO_write_data;
      irq_reg      <= 1'b0;
    end else begin
      prescale_reg <= tick ? '0 : prescale_reg + 1'b1;
      if (tick) begin
        timer_reg <= timer_reg + 15'd1;
        if (timer_reg == 15'h7FFF) irq_reg <= 1'b1;
      end
    end
  end

  assign timer_rd  = timer_reg;
  assign timer_irq = irq_reg;
`else
  assign timer_rd  = 15'h0000;
  assign timer_irq = 1'b0;
`endif

  // ---------------- combinational read mux ----------------
  always_comb begin
    io.IO_read_data = 15'h0000;
    case (io.IO_read_sel)
      3'd0: io.IO_read_data = scratch_reg;
      3'd1: io.IO_read_data = out_reg;
      3'd2: io.IO_read_data = sync2_reg;
      3'd3: io.IO_read_data = {tx_full, tx_empty, 8'h00, tx_count_reg};
      3'd4: io.IO_read_data = rx_head;
      3'd5: io.IO_read_data = {tx_ovf_reg, rx_udf_reg, 3'b000, rx_count_reg, tx_count_reg};
      3'd6: io.IO_read_data = timer_rd;
      default: io.IO_read_data = 15'h0000;
    endcase
  end

endmodule

// File: tb/tb_io_channel_responder.sv
// tb_io_channel_responder
//   Directed stimulus with a scoreboard. The stimulus process queues the
//   expected value of each observation it sets up; a negedge monitor pops
//   the queue and compares against the DUT, and separately checks every
//   tx handshake against a queue of expected downlink words.
module tb_io_channel_responder;

  localparam int K_RD  = 0;
  localparam int K_OUT = 1;
  localparam int K_TXV = 2;
  localparam int K_RXR = 3;
  localparam int K_IRQ = 4;

`ifdef IO_TIMER_EN
  localparam int TDIV = 2;
`else
  localparam int TDIV = 16;
`endif

  typedef struct {
    int          kind;
    int          tag;
    logic [14:0] exp;
  } chk_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] out_port;
  logic [14:0] in_port = '0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [14:0] tx_data;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [14:0] rx_data = '0;
  logic        timer_irq;

  io_channel_if io ();

  io_channel_responder #(
    .FIFO_DEPTH(8),
    .TIMER_DIV (TDIV),
    .OUT_RESET (15'h0000)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .io       (io.slave),
    .out_port (out_port),
    .in_port  (in_port),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .timer_irq(timer_irq)
  );

  always #5 clock = ~clock;

  chk_t        chk_q [$];
  logic [14:0] tx_q [$];
  int          errors = 0;
  int          checks = 0;
  int          tag_n  = 0;

  function automatic string kind_name(int k);
    case (k)
      K_RD:    return "read_data";
      K_OUT:   return "out_port";
      K_TXV:   return "tx_valid";
      K_RXR:   return "rx_ready";
      default: return "timer_irq";
    endcase
  endfunction

  // ---------------- monitor ----------------
  chk_t        mc;
  logic [14:0] act;
  logic [14:0] txe;

  always @(negedge clock) begin
    while (chk_q.size() > 0) begin
      mc = chk_q.pop_front();
      case (mc.kind)
        K_RD:    act = io.IO_read_data;
        K_OUT:   act = out_port;
        K_TXV:   act = {14'h0, tx_valid};
        K_RXR:   act = {14'h0, rx_ready};
        default: act = {14'h0, timer_irq};
      endcase
      checks++;
      if (act !== mc.exp) begin
        errors++;
        $display("FAIL %s #%0d: got %h, expected %h", kind_name(mc.kind), mc.tag, act, mc.exp);
      end else begin
        $display("ok   %s #%0d: %h", kind_name(mc.kind), mc.tag, act);
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_data: unexpected handshake with %h, expected none", tx_data);
      end else begin
        txe = tx_q.pop_front();
        if (tx_data !== txe) begin
          errors++;
          $display("FAIL tx_data: got %h, expected %h", tx_data, txe);
        end else begin
          $display("ok   tx_data: %h", tx_data);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [14:0] exp);
    chk_t c;
    c.kind = kind;
    c.tag  = tag_n;
    c.exp  = exp;
    tag_n++;
    chk_q.push_back(c);
  endtask

  // Present a read for one cycle and queue its expected data.
  task automatic rd(input logic [2:0] sel, input logic en, input logic [14:0] exp);
    io.IO_read_sel = sel;
    io.IO_read_en  = en;
    expect_val(K_RD, exp);
    step();
    io.IO_read_en  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [14:0] data);
    io.IO_write_sel  = sel;
    io.IO_write_data = data;
    io.IO_write_en   = 1'b1;
    step();
    io.IO_write_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    io.IO_read_sel   = 3'd0;
    io.IO_read_en    = 1'b0;
    io.IO_write_sel  = 3'd0;
    io.IO_write_data = '0;
    io.IO_write_en   = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state.
    expect_val(K_TXV, 15'd0);
    expect_val(K_RXR, 15'd1);
    expect_val(K_OUT, 15'h0000);
    expect_val(K_IRQ, 15'd0);
    rd(3'd0, 1'b0, 15'h0000);
    rd(3'd1, 1'b0, 15'h0000);
    rd(3'd2, 1'b0, 15'h0000);
    rd(3'd3, 1'b0, 15'h2000);
    rd(3'd4, 1'b0, 15'h0000);
    rd(3'd5, 1'b0, 15'h0000);
`ifndef IO_TIMER_EN
    rd(3'd6, 1'b0, 15'h0000);
`endif
    rd(3'd7, 1'b0, 15'h0000);

    // Scratch: same-cycle read sees the pre-edge value.
    io.IO_write_sel  = 3'd0;
    io.IO_write_data = 15'h1111;
    io.IO_write_en   = 1'b1;
    rd(3'd0, 1'b0, 15'h0000);
    io.IO_write_en   = 1'b0;
    rd(3'd0, 1'b0, 15'h1111);

    // Output latch.
    wr(3'd1, 15'h5A5A);
    expect_val(K_OUT, 15'h5A5A);
    rd(3'd1, 1'b0, 15'h5A5A);

    // Input synchroniser: two-cycle latency.
    in_port = 15'h1234;
    step();
    rd(3'd2, 1'b0, 15'h0000);
    rd(3'd2, 1'b0, 15'h1234);

    // TX overflow: nine pushes into a depth-8 FIFO with the device stalled.
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) tx_q.push_back(15'(i));
      wr(3'd3, 15'(i));
    end
    rd(3'd3, 1'b0, 15'h4008);
    rd(3'd5, 1'b0, 15'h4008);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    expect_val(K_TXV, 15'd0);
    step();
    tx_ready = 1'b0;
    wr(3'd5, 15'h4000);
    rd(3'd5, 1'b0, 15'h0000);

    // RX: three words, four pops, underflow on the last.
    rx_valid = 1'b1;
    rx_data  = 15'h0AAA; step();
    rx_data  = 15'h0BBB; step();
    rx_data  = 15'h0CCC; step();
    rx_valid = 1'b0;
    rd(3'd4, 1'b1, 15'h0AAA);
    rd(3'd4, 1'b1, 15'h0BBB);
    rd(3'd4, 1'b1, 15'h0CCC);
    rd(3'd4, 1'b1, 15'h0000);
    rd(3'd5, 1'b0, 15'h2000);

    // Same-cycle push and pop on a non-empty RX FIFO keeps the count.
    rx_valid = 1'b1;
    rx_data  = 15'h0DDD; step();
    rx_data  = 15'h0EEE;
    rd(3'd4, 1'b1, 15'h0DDD);
    rx_valid = 1'b0;
    rd(3'd5, 1'b0, 15'h2020);
    wr(3'd5, 15'h2000);
    rd(3'd5, 1'b0, 15'h0020);
    rd(3'd4, 1'b1, 15'h0EEE);

    // Underflow set beats a same-cycle clear.
    io.IO_write_sel  = 3'd5;
    io.IO_write_data = 15'h2000;
    io.IO_write_en   = 1'b1;
    rd(3'd4, 1'b1, 15'h0000);
    io.IO_write_en   = 1'b0;
    rd(3'd5, 1'b0, 15'h2000);
    wr(3'd5, 15'h2000);

    // Fill RX to depth: rx_ready falls, then returns after one pop.
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 15'h0100 + 15'(i);
      step();
    end
    rx_valid = 1'b0;
    expect_val(K_RXR, 15'd0);
    rd(3'd5, 1'b0, 15'h0100);
    expect_val(K_RXR, 15'd0);
    rd(3'd4, 1'b1, 15'h0100);
    expect_val(K_RXR, 15'd1);
    rd(3'd5, 1'b0, 15'h00E0);

    // Reset with both FIFOs partially full empties them.
    wr(3'd3, 15'h0077);
    wr(3'd3, 15'h0078);
    expect_val(K_TXV, 15'd1);
    rd(3'd5, 1'b0, 15'h00E2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_val(K_TXV, 15'd0);
    expect_val(K_RXR, 15'd1);
    rd(3'd3, 1'b0, 15'h2000);
    rd(3'd5, 1'b0, 15'h0000);
    rd(3'd4, 1'b0, 15'h0000);
    expect_val(K_OUT, 15'h0000);
    step();

`ifdef IO_TIMER_EN
    // Timer wrap: 0x7FFE with TIMER_DIV=2 wraps four edges after the write.
    wr(3'd6, 15'h7FFE);
    step(); step(); step();
    expect_val(K_IRQ, 15'd0);
    step();
    expect_val(K_IRQ, 15'd1);
    rd(3'd6, 1'b0, 15'h0000);
    // A write landing on the wrap edge wins.
    wr(3'd6, 15'h7FFE);
    step(); step(); step();
    wr(3'd6, 15'h1234);
    expect_val(K_IRQ, 15'd0);
    rd(3'd6, 1'b0, 15'h1234);
`endif

    step();
    step();
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL tx_drain: %0d words never delivered, expected 0", tx_q.size());
    end
    checks++;
    if (chk_q.size() != 0) begin
      errors++;
      $display("FAIL chk_drain: %0d checks unserviced, expected 0", chk_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
